// File: rtl/lcd_pkg.sv
// Shared LCD definitions: access-phase state encoding and default bus timing,
// used by both the read-side and the write-side LCD controllers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EN_HI   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } lcd_state_e;

  localparam int LCD_T_AS       = 3;
  localparam int LCD_T_EN       = 13;
  localparam int LCD_T_SAMPLE   = 10;
  localparam int LCD_T_REC      = 12;
  localparam int LCD_POLL_MAX   = 100000;
  localparam int LCD_TMR_W      = 16;
  localparam int LCD_POLL_CNT_W = 17;

  // A phase of N cycles loads N-1: the timer reaches zero on the phase's last cycle.
  function automatic logic [LCD_TMR_W-1:0] lcd_phase_load(input int cycles);
    return LCD_TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag; times each phase of an LCD bus access.
module lcd_phase_timer
  import lcd_pkg::*;
#(
  parameter int W = LCD_TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780-style bus read controller: single reads of status or data, and a
// busy-flag poll mode that repeats status reads until ready or timeout.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_EN     = LCD_T_EN,
  parameter int T_SAMPLE = LCD_T_SAMPLE,
  parameter int T_REC    = LCD_T_REC,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic       poll_start,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_busy,
  output logic [6:0] rsp_addr,
  output logic       poll_done,
  output logic       poll_timeout,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_DATA_OE,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output lcd_state_e dbg_state
);

  // Handshake: a request is taken on any clock edge where req_ready (IDLE) is
  // high and req_valid or poll_start is high; poll_start has priority, and
  // requests seen outside IDLE are dropped, never queued.

  localparam logic [LCD_TMR_W-1:0]    AS_LOAD   = lcd_phase_load(T_AS);
  localparam logic [LCD_TMR_W-1:0]    EN_LOAD   = lcd_phase_load(T_EN);
  localparam logic [LCD_TMR_W-1:0]    REC_LOAD  = lcd_phase_load(T_REC);
  localparam logic [LCD_TMR_W-1:0]    SAMPLE_AT = LCD_TMR_W'(T_EN - T_SAMPLE);
  localparam logic [LCD_POLL_CNT_W:0] POLL_LIM  = (LCD_POLL_CNT_W + 1)'(POLL_MAX);

  lcd_state_e state_q, state_d;
  logic       rs_q, rs_d;
  logic       poll_q, poll_d;
  logic [LCD_POLL_CNT_W-1:0] cnt_q, cnt_d;
  logic [LCD_POLL_CNT_W:0]   cnt_inc;

  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_rw_q, lcd_rw_d;
  logic       lcd_en_q, lcd_en_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_busy_q, rsp_busy_d;
  logic [6:0] rsp_addr_q, rsp_addr_d;
  logic       poll_done_q, poll_done_d;
  logic       poll_timeout_q, poll_timeout_d;

  logic                 tmr_load;
  logic [LCD_TMR_W-1:0] tmr_val;
  logic [LCD_TMR_W-1:0] tmr_count;
  logic                 tmr_zero;

  lcd_phase_timer #(.W(LCD_TMR_W)) u_timer (
    .clk      (CLOCK_50),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d        = state_q;
    rs_d           = rs_q;
    poll_d         = poll_q;
    cnt_d          = cnt_q;
    lcd_rs_d       = lcd_rs_q;
    lcd_rw_d       = lcd_rw_q;
    lcd_en_d       = lcd_en_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_busy_d     = rsp_busy_q;
    rsp_addr_d     = rsp_addr_q;
    poll_done_d    = 1'b0;
    poll_timeout_d = 1'b0;
    tmr_load       = 1'b0;
    tmr_val        = AS_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (poll_start) begin
          state_d  = ST_SETUP;
          rs_d     = 1'b0;
          poll_d   = 1'b1;
          cnt_d    = '0;
          lcd_rs_d = 1'b0;
          lcd_rw_d = 1'b1;
          tmr_load = 1'b1;
        end else if (req_valid) begin
          state_d  = ST_SETUP;
          rs_d     = req_rs;
          poll_d   = 1'b0;
          lcd_rs_d = req_rs;
          lcd_rw_d = 1'b1;
          tmr_load = 1'b1;
        end
      end

      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_EN_HI;
          lcd_en_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = EN_LOAD;
        end
      end

      ST_EN_HI: begin
        // The timer reads T_EN-k during EN-high cycle k.
        if (tmr_count == SAMPLE_AT) begin
          rsp_data_d = LCD_DATA_IN;
          rsp_busy_d = ~rs_q & LCD_DATA_IN[7];
          rsp_addr_d = rs_q ? 7'd0 : LCD_DATA_IN[6:0];
        end
        if (tmr_zero) begin
          state_d  = ST_RECOVER;
          lcd_en_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = REC_LOAD;
        end
      end

      ST_RECOVER: begin
        if (tmr_zero) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (poll_q) begin
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (!rsp_busy_q) begin
              poll_done_d = 1'b1;
            end else if (cnt_inc >= POLL_LIM) begin
              poll_timeout_d = 1'b1;
            end
          end
        end
      end

      ST_RESP: begin
        // The poll outcome was decided on entry; the pulses are visible now.
        if (poll_q && !poll_done_q && !poll_timeout_q) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          poll_d   = 1'b0;
          rs_d     = 1'b0;
          lcd_rs_d = 1'b0;
          lcd_rw_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        poll_d   = 1'b0;
        lcd_rs_d = 1'b0;
        lcd_rw_d = 1'b0;
        lcd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      rs_q           <= 1'b0;
      poll_q         <= 1'b0;
      cnt_q          <= '0;
      lcd_rs_q       <= 1'b0;
      lcd_rw_q       <= 1'b0;
      lcd_en_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'd0;
      rsp_busy_q     <= 1'b0;
      rsp_addr_q     <= 7'd0;
      poll_done_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rs_q           <= rs_d;
      poll_q         <= poll_d;
      cnt_q          <= cnt_d;
      lcd_rs_q       <= lcd_rs_d;
      lcd_rw_q       <= lcd_rw_d;
      lcd_en_q       <= lcd_en_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_busy_q     <= rsp_busy_d;
      rsp_addr_q     <= rsp_addr_d;
      poll_done_q    <= poll_done_d;
      poll_timeout_q <= poll_timeout_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_busy     = rsp_busy_q;
  assign rsp_addr     = rsp_addr_q;
  assign poll_done    = poll_done_q;
  assign poll_timeout = poll_timeout_q;
  assign LCD_DATA_OE  = 1'b0;
  assign LCD_RS       = lcd_rs_q;
  assign LCD_RW       = lcd_rw_q;
  assign LCD_EN       = lcd_en_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/lcd_bus_reader.md
LCD_BUS_READER -- requirements
Module: lcd_bus_reader

Interface
REQ-001 Parameter T_AS, default 3: CLOCK_50 cycles with RS/RW stable before LCD_EN rises.
REQ-002 Parameter T_EN, default 13: cycles LCD_EN is held high.
REQ-003 Parameter T_SAMPLE, default 10: cycle within EN-high at which LCD_DATA_IN is captured; legal range 1..T_EN-1.
REQ-004 Parameter T_REC, default 12: cycles LCD_EN is held low after a read before the next access.
REQ-005 Parameter POLL_MAX, default 100000: maximum busy-flag reads in poll mode before timeout.
REQ-006 CLOCK_50  in  1  50 MHz clock, the block's only clock.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  1  single-read request.
REQ-009 req_rs  in  1  register select for the read: 0 = status/address, 1 = DDRAM/CGRAM data.
REQ-010 poll_start  in  1  one-cycle pulse that starts busy-flag polling.
REQ-011 req_ready  out  1  high in IDLE only.
REQ-012 rsp_valid  out  1  one-cycle pulse when rsp_* outputs are valid.
REQ-013 rsp_data  out  8  captured byte.
REQ-014 rsp_busy  out  1  rsp_data[7] when the read used RS=0, else 0.
REQ-015 rsp_addr  out  7  rsp_data[6:0] when the read used RS=0, else 0.
REQ-016 poll_done  out  1  one-cycle pulse when the busy flag is read as 0 in poll mode.
REQ-017 poll_timeout  out  1  one-cycle pulse when POLL_MAX reads all return busy.
REQ-018 LCD_DATA_IN  in  8  LCD data bus, input side.
REQ-019 LCD_DATA_OE  out  1  FPGA bus driver enable; constant 0 from this block.
REQ-020 LCD_RS, LCD_RW, LCD_EN  out  1 each  LCD control lines.

Function
REQ-021 States: IDLE, SETUP, EN_HI, RECOVER, RESP.
- IDLE: req_valid -> SETUP, with req_rs latched.
- IDLE: poll_start -> SETUP, with RS=0 and poll mode set.
- IDLE: if both are asserted in the same cycle, poll_start wins and req_valid is ignored.
REQ-022 SETUP: LCD_RW=1 and LCD_RS=latched rs; LCD_EN=0 for T_AS cycles; then -> EN_HI.
REQ-023 EN_HI: LCD_EN=1 for exactly T_EN cycles; LCD_DATA_IN is registered on EN-high cycle T_SAMPLE (counting from 1); then -> RECOVER.
REQ-024 RECOVER: LCD_EN=0 and RW/RS held for T_REC cycles; then -> RESP.
REQ-025 RESP lasts one cycle and drives rsp_valid=1.
- Non-poll: -> IDLE.
- Poll with rsp_busy=0: assert poll_done, -> IDLE.
- Poll with rsp_busy=1 and read count < POLL_MAX: -> SETUP.
- Poll with rsp_busy=1 and read count = POLL_MAX: assert poll_timeout, -> IDLE.
REQ-026 Single-read latency from the req_valid accept edge to rsp_valid is T_AS+T_EN+T_REC+1 cycles; 29 with defaults.
REQ-027 The poll read counter is 17 bits, clears on poll_start accept, increments at each RESP, and never wraps.
REQ-028 rsp_data, rsp_busy and rsp_addr hold their last value until the next capture.
REQ-029 In IDLE, LCD_RW=0, LCD_RS=0 and LCD_EN=0, so the bus is free for the write-side controller.
REQ-030 req_valid and poll_start arriving outside IDLE are ignored; they are not queued.
REQ-031 All LCD_* outputs and all rsp_* outputs are driven directly from flops; no combinational path.

Reset
REQ-032 RST_N low asynchronously forces the following values, including mid-cycle with EN high:
- State IDLE.
- LCD_EN=0, LCD_RW=0, LCD_RS=0, LCD_DATA_OE=0.
- rsp_valid=0, rsp_data=0, rsp_busy=0, rsp_addr=0.
- poll_done=0, poll_timeout=0.
- All counters cleared; poll mode cleared.
REQ-033 The first request is accepted on the first clock edge after RST_N deasserts.

Structure
REQ-034 The state enumeration and the default timing constants live in the shared package lcd_pkg, which the LCD write controller also uses.
REQ-035 Phase timing uses one sub-module, lcd_phase_timer: a loadable down-counter with a zero flag.

Verification
REQ-036 Single read: req_valid with req_rs=0 while LCD_DATA_IN=8'hA5 during EN_HI -> rsp_valid 29 cycles after accept, rsp_busy=1, rsp_addr=7'h25, EN high for exactly 13 cycles.
REQ-037 Data read: req_rs=1 with LCD_DATA_IN=8'h48 -> rsp_data=8'h48, rsp_busy=0, rsp_addr=0, and LCD_RS=1 throughout SETUP to RECOVER.
REQ-038 Poll: model returns busy for 3 reads, then 8'h05 -> 4 rsp_valid pulses, poll_done once, poll_timeout never asserted.
REQ-039 Timeout: POLL_MAX overridden to 4, model always returns busy -> exactly 4 reads, then poll_timeout pulse, then IDLE with req_ready=1.
REQ-040 Reset during EN_HI -> LCD_EN falls asynchronously, no rsp_valid, req_ready=1 on the first edge after RST_N rises.
REQ-041 req_valid and poll_start in the same cycle -> a poll runs with RS=0; a req_valid pulse during the poll produces no extra read.
